// File: rtl/control_bank_pkg.sv
// Shared types, default sizing and ring-pointer helper for the control-word bank.
package control_bank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int unsigned DEF_WORD_W    = 16;
  localparam int unsigned DEF_NUM_SLOTS = 64;

  // Next slot in ring order; wraps from the last slot back to slot 0.
  function automatic int unsigned ring_next(input int unsigned ptr, input int unsigned num_slots);
    return (ptr >= num_slots - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/slot_ring_ptr.sv
// Burst address pointer with ring wrap, plus the remaining-word down-counter.
module slot_ring_ptr
  import control_bank_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int unsigned ADDR_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_ptr,
  input  logic [ADDR_W:0]   load_cnt,
  input  logic              step,
  output logic [ADDR_W-1:0] ptr,
  output logic              zero,
  output logic              last
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0] remaining;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
    end else if (load) begin
      ptr       <= load_ptr;
      remaining <= load_cnt;
    end else if (step && !zero) begin
      ptr       <= ADDR_W'(ring_next(32'(ptr), NUM_SLOTS));
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign zero = (remaining == '0);
  assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/control_bank.sv
// Double-buffered control-word bank: shadow writes (single or burst) and atomic commit to live outputs.
module control_bank
  import control_bank_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int unsigned ADDR_W    = $clog2(NUM_SLOTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [WORD_W-1:0]           wr_data,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic                        wr_burst,
  input  logic [ADDR_W:0]             burst_len,
  input  logic                        commit_req,
  output logic [NUM_SLOTS*WORD_W-1:0] combined_out,
  output logic                        updated,
  output logic [NUM_SLOTS-1:0]        dirty,
  output logic                        busy
);

  localparam int unsigned     CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_SLOTS - 1);

  state_t state, next_state;

  logic [NUM_SLOTS-1:0][WORD_W-1:0] shadow;
  logic [NUM_SLOTS-1:0][WORD_W-1:0] live;

  logic              accept;
  logic              hs;
  logic              addr_ok;
  logic [CNT_W-1:0]  len_eff;
  logic [CNT_W-1:0]  load_cnt;
  logic [ADDR_W-1:0] load_ptr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic              load;
  logic              step;
  logic [ADDR_W-1:0] ptr;
  logic              cnt_zero;
  logic              cnt_last;

  // Handshake qualification shared by the FSM and the storage.
  assign accept   = (state != COMMIT) && !rst;
  assign hs       = wr_valid && accept;
  assign addr_ok  = ({1'b0, wr_addr} <= LAST_SLOT);
  assign len_eff  = (burst_len == '0) ? CNT_W'(1) : burst_len;
  assign load_cnt = len_eff - CNT_W'(1);
  // An out-of-range burst start discards the first word and continues from slot 0.
  assign load_ptr = addr_ok ? ADDR_W'(ring_next(32'(wr_addr), NUM_SLOTS)) : '0;

  slot_ring_ptr #(
    .NUM_SLOTS (NUM_SLOTS),
    .ADDR_W    (ADDR_W)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_ptr (load_ptr),
    .load_cnt (load_cnt),
    .step     (step),
    .ptr      (ptr),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A burst start outranks a same-cycle commit request.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (hs && wr_burst)  next_state = (load_cnt != '0) ? BURST : COMMIT;
        else if (commit_req) next_state = COMMIT;
      end
      BURST: begin
        if (cnt_zero || (hs && cnt_last)) next_state = COMMIT;
      end
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = ptr;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = accept;
        wr_en    = hs && addr_ok;
        wr_idx   = wr_addr;
        load     = hs && wr_burst;
      end
      BURST: begin
        wr_ready = accept;
        busy     = 1'b1;
        wr_en    = hs;
        step     = hs;
      end
      COMMIT: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Shadow/live storage; live only moves on the single COMMIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      live    <= '0;
      dirty   <= '0;
      updated <= 1'b0;
    end else begin
      updated <= (state == COMMIT);
      if (wr_en) begin
        shadow[wr_idx] <= wr_data;
        dirty[wr_idx]  <= 1'b1;
      end
      if (state == COMMIT) begin
        live  <= shadow;
        dirty <= '0;
      end
    end
  end

  assign combined_out = live;

endmodule

// File: tb/tb_control_bank.sv
// Scoreboarded bench for control_bank: default 64x16 instance plus a 5x8 instance for wrap/range cases.
module tb_control_bank;

  localparam int W  = 16;
  localparam int N  = 64;
  localparam int A  = 6;
  localparam int SW = 8;
  localparam int SN = 5;
  localparam int SA = 3;

  logic clk = 1'b0;
  logic rst;

  logic           wr_valid, wr_ready, wr_burst, commit_req, updated, busy;
  logic [W-1:0]   wr_data;
  logic [A-1:0]   wr_addr;
  logic [A:0]     burst_len;
  logic [N*W-1:0] combined_out;
  logic [N-1:0]   dirty;

  logic            s_wr_valid, s_wr_ready, s_wr_burst, s_commit_req, s_updated, s_busy;
  logic [SW-1:0]   s_wr_data;
  logic [SA-1:0]   s_wr_addr;
  logic [SA:0]     s_burst_len;
  logic [SN*SW-1:0] s_combined_out;
  logic [SN-1:0]   s_dirty;

  logic [N-1:0][W-1:0] mshadow;
  logic [N-1:0][W-1:0] mlive;
  logic [N-1:0]        mdirty;
  logic [N*W-1:0]      exp_q[$];
  logic [N*W-1:0]      mon_e;
  int                  mon_bad;

  int checks   = 0;
  int failures = 0;

  control_bank dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_addr(wr_addr), .wr_burst(wr_burst), .burst_len(burst_len), .commit_req(commit_req),
    .combined_out(combined_out), .updated(updated), .dirty(dirty), .busy(busy)
  );

  control_bank #(.WORD_W(SW), .NUM_SLOTS(SN)) dut_s (
    .clk(clk), .rst(rst), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_data(s_wr_data),
    .wr_addr(s_wr_addr), .wr_burst(s_wr_burst), .burst_len(s_burst_len), .commit_req(s_commit_req),
    .combined_out(s_combined_out), .updated(s_updated), .dirty(s_dirty), .busy(s_busy)
  );

  always #5 clk = ~clk;

  // Every update pulse must match the next queued commit image.
  always @(negedge clk) begin
    if (!rst && updated) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL update_unexpected got updated=1 want no pulse");
      end else begin
        mon_e = exp_q.pop_front();
        if (combined_out !== mon_e) begin
          failures++;
          mon_bad = -1;
          for (int i = 0; i < N; i++)
            if (mon_bad < 0 && combined_out[i*W +: W] !== mon_e[i*W +: W]) mon_bad = i;
          if (mon_bad < 0) mon_bad = 0;
          $display("FAIL commit_content slot=%0d got=%h want=%h", mon_bad,
                   combined_out[mon_bad*W +: W], mon_e[mon_bad*W +: W]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    mshadow = '0;
    mlive   = '0;
    mdirty  = '0;
  endtask

  task automatic do_write(input logic [A-1:0] addr, input logic [W-1:0] data, input bit commit);
    wr_valid = 1'b1; wr_addr = addr; wr_data = data; wr_burst = 1'b0; commit_req = commit;
    tick();
    wr_valid = 1'b0; commit_req = 1'b0;
    mshadow[addr] = data;
    mdirty[addr]  = 1'b1;
    if (commit) begin
      exp_q.push_back(mshadow);
      mlive  = mshadow;
      mdirty = '0;
    end
  endtask

  task automatic test_reset();
    do_write(A'($urandom_range(0, N-1)), W'($urandom), 1'b0);
    do_write(A'($urandom_range(0, N-1)), W'($urandom), 1'b1);
    tick(); tick();
    do_write(6'd9, W'($urandom), 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if (combined_out !== '0) begin failures++; $display("FAIL reset_combined got=%h want=0", combined_out[W-1:0]); end
    checks++; if (dirty !== '0)        begin failures++; $display("FAIL reset_dirty got=%h want=0", dirty); end
    checks++; if (wr_ready !== 1'b0)   begin failures++; $display("FAIL reset_wr_ready got=%b want=0", wr_ready); end
    checks++; if (updated !== 1'b0)    begin failures++; $display("FAIL reset_updated got=%b want=0", updated); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    #1;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", wr_ready); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_release_busy got=%b want=0", busy); end
  endtask

  task automatic test_single();
    logic [N*W-1:0] old_live;
    old_live = mlive;
    do_write(6'd5, 16'hBEEF, 1'b0);
    do_write(6'd63, 16'h1234, 1'b0);
    checks++; if (dirty !== mdirty) begin failures++; $display("FAIL single_dirty got=%h want=%h", dirty, mdirty); end
    checks++; if (combined_out !== old_live) begin failures++; $display("FAIL single_live_held got=%h want=%h", combined_out[95:80], old_live[95:80]); end
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    exp_q.push_back(mshadow); mlive = mshadow; mdirty = '0;
    checks++; if (wr_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_commit_state got ready=%b busy=%b want ready=0 busy=1", wr_ready, busy); end
    checks++; if (combined_out !== old_live) begin failures++; $display("FAIL single_commit_early got=%h want=%h", combined_out[95:80], old_live[95:80]); end
    tick();
    checks++; if (updated !== 1'b1) begin failures++; $display("FAIL single_updated got=%b want=1", updated); end
    checks++; if (combined_out[95:80] !== 16'hBEEF) begin failures++; $display("FAIL single_slot5 got=%h want=beef", combined_out[95:80]); end
    checks++; if (combined_out[1023:1008] !== 16'h1234) begin failures++; $display("FAIL single_slot63 got=%h want=1234", combined_out[1023:1008]); end
    checks++; if (dirty !== '0) begin failures++; $display("FAIL single_dirty_clear got=%h want=0", dirty); end
    tick();
    checks++; if (updated !== 1'b0) begin failures++; $display("FAIL single_updated_once got=%b want=0", updated); end
  endtask

  task automatic test_wrap_burst();
    wr_valid = 1'b1; wr_burst = 1'b1; wr_addr = 6'd62; burst_len = 7'd4; wr_data = 16'd1;
    tick();
    wr_valid = 1'b0; wr_burst = 1'b0;
    mshadow[62] = 16'd1; mdirty[62] = 1'b1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL burst_busy_start got=%b want=1", busy); end
    for (int k = 2; k <= 4; k++) begin
      commit_req = (k == 3);
      tick();
      commit_req = 1'b0;
      checks++; if (busy !== 1'b1 || updated !== 1'b0) begin failures++; $display("FAIL burst_gap k=%0d got busy=%b upd=%b want busy=1 upd=0", k, busy, updated); end
      wr_valid = 1'b1; wr_addr = 6'd7; wr_burst = 1'b1; wr_data = W'(k);
      tick();
      wr_valid = 1'b0; wr_burst = 1'b0;
      mshadow[(61 + k) % N] = W'(k); mdirty[(61 + k) % N] = 1'b1;
      if (k == 4) begin
        exp_q.push_back(mshadow); mlive = mshadow; mdirty = '0;
        checks++; if (wr_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL burst_autocommit got ready=%b busy=%b want ready=0 busy=1", wr_ready, busy); end
      end else begin
        checks++; if (dirty !== mdirty) begin failures++; $display("FAIL burst_dirty k=%0d got=%h want=%h", k, dirty, mdirty); end
      end
    end
    tick();
    checks++; if (updated !== 1'b1) begin failures++; $display("FAIL burst_updated got=%b want=1", updated); end
    checks++; if (combined_out[15:0] !== 16'd3 || combined_out[31:16] !== 16'd4) begin failures++; $display("FAIL burst_wrap_slots got s0=%h s1=%h want 3 4", combined_out[15:0], combined_out[31:16]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_write_and_commit();
    do_write(6'd0, 16'hAAAA, 1'b1);
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL wc_ready_low got=%b want=0", wr_ready); end
    tick();
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL wc_ready_back got=%b want=1", wr_ready); end
    checks++; if (combined_out[15:0] !== 16'hAAAA) begin failures++; $display("FAIL wc_slot0 got=%h want=aaaa", combined_out[15:0]); end
  endtask

  task automatic test_reset_mid_burst();
    wr_valid = 1'b1; wr_burst = 1'b1; wr_addr = 6'd10; burst_len = 7'd8; wr_data = 16'h0100;
    tick();
    wr_burst = 1'b0; wr_data = 16'h0101;
    tick();
    wr_data = 16'h0102;
    tick();
    wr_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (combined_out !== '0 || dirty !== '0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_clear got busy=%b dirty=%h slot0=%h want all zero", busy, dirty, combined_out[15:0]); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    #1;
    checks++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got ready=%b busy=%b want ready=1 busy=0", wr_ready, busy); end
    do_write(6'd7, 16'h5A5A, 1'b1);
    tick();
    checks++; if (updated !== 1'b1 || combined_out[127:112] !== 16'h5A5A) begin failures++; $display("FAIL midrst_after got upd=%b s7=%h want upd=1 s7=5a5a", updated, combined_out[127:112]); end
    checks++; if (combined_out[175:160] !== 16'h0000) begin failures++; $display("FAIL midrst_no_partial got s10=%h want=0", combined_out[175:160]); end
  endtask

  task automatic test_small();
    s_wr_valid = 1'b1; s_wr_addr = 3'd6; s_wr_data = 8'h77;
    tick();
    s_wr_valid = 1'b0;
    checks++; if (s_dirty !== 5'b0 || s_busy !== 1'b0) begin failures++; $display("FAIL small_discard got dirty=%b busy=%b want 0 0", s_dirty, s_busy); end
    s_wr_valid = 1'b1; s_wr_burst = 1'b1; s_wr_addr = 3'd3; s_burst_len = 4'd5; s_wr_data = 8'h11;
    tick();
    s_wr_burst = 1'b0;
    checks++; if (s_dirty !== 5'b01000 || s_busy !== 1'b1) begin failures++; $display("FAIL small_burst_first got dirty=%b busy=%b want 01000 1", s_dirty, s_busy); end
    for (int k = 2; k <= 5; k++) begin
      s_wr_data = SW'(k * 17);
      tick();
    end
    s_wr_valid = 1'b0;
    checks++; if (s_wr_ready !== 1'b0) begin failures++; $display("FAIL small_autocommit got ready=%b want=0", s_wr_ready); end
    tick();
    checks++; if (s_updated !== 1'b1) begin failures++; $display("FAIL small_updated got=%b want=1", s_updated); end
    checks++; if (s_combined_out !== 40'h2211554433) begin failures++; $display("FAIL small_ring got=%h want=2211554433", s_combined_out); end
    checks++; if (s_dirty !== 5'b0) begin failures++; $display("FAIL small_dirty_clear got=%b want=0", s_dirty); end
  endtask

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; wr_data = '0; wr_addr = '0; wr_burst = 1'b0; burst_len = '0; commit_req = 1'b0;
    s_wr_valid = 1'b0; s_wr_data = '0; s_wr_addr = '0; s_wr_burst = 1'b0; s_burst_len = '0; s_commit_req = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    test_reset();
    tick();
    test_single();
    test_wrap_burst();
    tick();
    test_write_and_commit();
    tick();
    test_reset_mid_burst();
    tick();
    test_small();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL missing_updates got pending=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
